// File: rtl/vip_ycbcr444_rgb888.sv
// YCbCr444 -> RGB888 colour-space converter.
// Three-stage free-running pipeline: constant products, signed sums with
// optional rounding offset, then saturation to 8 bits. Sideband strobes
// are delayed by the same three cycles so they stay aligned with the data.
module vip_ycbcr444_rgb888 #(
    parameter bit ROUND_EN = 1'b1,
    parameter bit GATE_OUT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        per_frame_vsync,
    input  logic        per_frame_href,
    input  logic        per_frame_clken,
    input  logic [23:0] per_img_ycbcr,
    output logic        post_frame_vsync,
    output logic        post_frame_href,
    output logic        post_frame_clken,
    output logic [23:0] post_img_rgb888
);

    localparam logic signed [18:0] RND = ROUND_EN ? 19'sd128 : 19'sd0;

    logic [7:0]         y_in;
    logic [7:0]         cb_in;
    logic [7:0]         cr_in;
    logic signed [8:0]  dcb;
    logic signed [8:0]  dcr;
    logic signed [18:0] dcb_x;
    logic signed [18:0] dcr_x;
    logic signed [18:0] y256;

    // stage 1 registers
    logic signed [18:0] y256_q;
    logic signed [18:0] r_cr_q;
    logic signed [18:0] g_cb_q;
    logic signed [18:0] g_cr_q;
    logic signed [18:0] b_cb_q;

    // stage 2 registers
    logic signed [18:0] sum_r_q;
    logic signed [18:0] sum_g_q;
    logic signed [18:0] sum_b_q;

    // stage 3 register
    logic [23:0]        rgb_q;

    // sideband delay lines, bit 2 is the output tap
    logic [2:0]         vsync_d;
    logic [2:0]         href_d;
    logic [2:0]         clken_d;

    assign y_in  = per_img_ycbcr[23:16];
    assign cb_in = per_img_ycbcr[15:8];
    assign cr_in = per_img_ycbcr[7:0];

    // Offset-binary to two's complement: the 9-bit subtraction wraps into
    // the correct signed value for the whole 0..255 range.
    assign dcb   = $signed({1'b0, cb_in} - 9'd128);
    assign dcr   = $signed({1'b0, cr_in} - 9'd128);
    assign dcb_x = {{10{dcb[8]}}, dcb};
    assign dcr_x = {{10{dcr[8]}}, dcr};
    assign y256  = $signed({3'b000, y_in, 8'h00});

    // Non-negative sums below 2^16 map straight to bits [15:8]; anything
    // negative or at/above 2^16 saturates. This is the >>8 plus clamp.
    function automatic logic [7:0] clamp8(input logic signed [18:0] s);
        logic [7:0] v;
        if (s[18])
            v = 8'h00;
        else if (s[17:16] != 2'b00)
            v = 8'hFF;
        else
            v = s[15:8];
        return v;
    endfunction

    // Stage 1: register the scaled luma and the constant chroma products.
    always_ff @(posedge clk) begin
        if (rst) begin
            y256_q <= '0;
            r_cr_q <= '0;
            g_cb_q <= '0;
            g_cr_q <= '0;
            b_cb_q <= '0;
        end else begin
            y256_q <= y256;
            r_cr_q <= dcr_x * 19'sd359;
            g_cb_q <= dcb_x * 19'sd88;
            g_cr_q <= dcr_x * 19'sd183;
            b_cb_q <= dcb_x * 19'sd454;
        end
    end

    // Stage 2: per-channel signed sums including the rounding offset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_r_q <= '0;
            sum_g_q <= '0;
            sum_b_q <= '0;
        end else begin
            sum_r_q <= y256_q + r_cr_q + RND;
            sum_g_q <= y256_q - g_cb_q - g_cr_q + RND;
            sum_b_q <= y256_q + b_cb_q + RND;
        end
    end

    // Stage 3: clamp to 8 bits; gating looks at the href bit that becomes
    // post_frame_href on this same edge.
    always_ff @(posedge clk) begin
        if (rst)
            rgb_q <= '0;
        else if (GATE_OUT && !href_d[1])
            rgb_q <= '0;
        else
            rgb_q <= {clamp8(sum_r_q), clamp8(sum_g_q), clamp8(sum_b_q)};
    end

    // Sideband delay lines matching the three data stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_d <= '0;
            href_d  <= '0;
            clken_d <= '0;
        end else begin
            vsync_d <= {vsync_d[1:0], per_frame_vsync};
            href_d  <= {href_d[1:0], per_frame_href};
            clken_d <= {clken_d[1:0], per_frame_clken};
        end
    end

    assign post_frame_vsync = vsync_d[2];
    assign post_frame_href  = href_d[2];
    assign post_frame_clken = clken_d[2];
    assign post_img_rgb888  = rgb_q;

endmodule

// File: tb/tb_vip_ycbcr444_rgb888.sv
// Bench for vip_ycbcr444_rgb888: one instance with default parameters
// (rounding, gated) and one with truncation and no gating, both driven
// from the same stimulus and checked every cycle against an integer model.
module tb_vip_ycbcr444_rgb888;

    logic        clk = 1'b0;
    logic        rst;
    logic        vsync;
    logic        href;
    logic        clken;
    logic [23:0] ycbcr;

    logic        a_vsync, a_href, a_clken;
    logic [23:0] a_rgb;
    logic        b_vsync, b_href, b_clken;
    logic [23:0] b_rgb;

    int checks = 0;
    int errors = 0;

    localparam int HN = 16384;
    bit          h_rst   [HN];
    bit          h_vsync [HN];
    bit          h_href  [HN];
    bit          h_clken [HN];
    logic [23:0] h_pix   [HN];
    int          cyc = 0;

    always #5 clk = ~clk;

    vip_ycbcr444_rgb888 dut_a (
        .clk              (clk),
        .rst              (rst),
        .per_frame_vsync  (vsync),
        .per_frame_href   (href),
        .per_frame_clken  (clken),
        .per_img_ycbcr    (ycbcr),
        .post_frame_vsync (a_vsync),
        .post_frame_href  (a_href),
        .post_frame_clken (a_clken),
        .post_img_rgb888  (a_rgb)
    );

    vip_ycbcr444_rgb888 #(.ROUND_EN(1'b0), .GATE_OUT(1'b0)) dut_b (
        .clk              (clk),
        .rst              (rst),
        .per_frame_vsync  (vsync),
        .per_frame_href   (href),
        .per_frame_clken  (clken),
        .per_img_ycbcr    (ycbcr),
        .post_frame_vsync (b_vsync),
        .post_frame_href  (b_href),
        .post_frame_clken (b_clken),
        .post_img_rgb888  (b_rgb)
    );

    // Reference: integer colour equations, floor shift, saturate.
    function automatic logic [7:0] sat8(input int s, input bit rnd);
        int t;
        int q;
        t = rnd ? s + 128 : s;
        q = t >>> 8;
        if (q < 0) return 8'd0;
        if (q > 255) return 8'd255;
        return q[7:0];
    endfunction

    function automatic logic [23:0] ref_rgb(input logic [23:0] p, input bit rnd);
        int y;
        int dcb;
        int dcr;
        y   = int'(p[23:16]);
        dcb = int'(p[15:8]) - 128;
        dcr = int'(p[7:0]) - 128;
        return {sat8(256*y + 359*dcr, rnd),
                sat8(256*y - 88*dcb - 183*dcr, rnd),
                sat8(256*y + 454*dcb, rnd)};
    endfunction

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Record what each edge samples.
    always @(posedge clk) begin
        if (cyc < HN) begin
            h_rst[cyc]   = rst;
            h_vsync[cyc] = vsync;
            h_href[cyc]  = href;
            h_clken[cyc] = clken;
            h_pix[cyc]   = ycbcr;
        end
        cyc++;
    end

    // Output after edge j reflects the input sampled at edge j-2, unless a
    // reset was sampled at any of edges j-2..j.
    always @(negedge clk) begin
        if (cyc >= 3 && cyc <= HN) begin
            int j;
            int i;
            bit zap;
            logic        e_vs, e_hr, e_ce;
            logic [23:0] e_a, e_b;
            j   = cyc - 1;
            i   = j - 2;
            zap = h_rst[j] | h_rst[j-1] | h_rst[j-2];
            e_vs = zap ? 1'b0 : h_vsync[i];
            e_hr = zap ? 1'b0 : h_href[i];
            e_ce = zap ? 1'b0 : h_clken[i];
            e_a  = (zap || !h_href[i]) ? 24'h0 : ref_rgb(h_pix[i], 1'b1);
            e_b  = zap ? 24'h0 : ref_rgb(h_pix[i], 1'b0);
            check("a_vsync", {23'h0, a_vsync}, {23'h0, e_vs});
            check("a_href",  {23'h0, a_href},  {23'h0, e_hr});
            check("a_clken", {23'h0, a_clken}, {23'h0, e_ce});
            check("a_rgb",   a_rgb, e_a);
            check("b_href",  {23'h0, b_href},  {23'h0, e_hr});
            check("b_rgb",   b_rgb, e_b);
        end
    end

    task automatic step(input bit vs, input bit hr, input bit ce, input logic [23:0] p);
        vsync = vs;
        href  = hr;
        clken = ce;
        ycbcr = p;
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic [23:0] p, input bit hr);
        for (int k = 0; k < 4; k++) step(1'b0, hr, hr, p);
    endtask

    initial begin
        logic [7:0] corner [7];
        rst = 1'b1; vsync = 1'b0; href = 1'b0; clken = 1'b0; ycbcr = 24'h0;
        corner[0] = 8'd0;   corner[1] = 8'd1;   corner[2] = 8'd127; corner[3] = 8'd128;
        corner[4] = 8'd129; corner[5] = 8'd254; corner[6] = 8'd255;

        // model pinned by hand-worked values
        check("model_red",  ref_rgb(24'h4C55FF, 1'b1), 24'hFE0000);
        check("model_zero", ref_rgb(24'h000000, 1'b0), 24'h008700);

        // reset state
        step(1'b1, 1'b1, 1'b1, 24'hFFFFFF);
        step(1'b1, 1'b1, 1'b1, 24'hFFFFFF);
        step(1'b1, 1'b1, 1'b1, 24'hFFFFFF);
        check("rst_rgb",  a_rgb, 24'h0);
        check("rst_href", {23'h0, a_href}, 24'h0);
        check("rst_vs",   {23'h0, a_vsync}, 24'h0);
        rst = 1'b0;

        // grey
        hold(24'h808080, 1'b1);
        check("grey_rgb",   a_rgb, 24'h808080);
        check("grey_href",  {23'h0, a_href}, 24'h1);
        check("grey_clken", {23'h0, a_clken}, 24'h1);
        check("grey_trunc", b_rgb, 24'h808080);

        // red
        hold(24'h4C55FF, 1'b1);
        check("red_rgb",   a_rgb, 24'hFE0000);
        check("red_trunc", b_rgb, 24'hFE0000);

        // saturation
        hold(24'hFF80FF, 1'b1);
        check("sat_hi",       a_rgb, 24'hFFA4FF);
        check("sat_hi_trunc", b_rgb, 24'hFFA4FF);
        hold(24'h000000, 1'b1);
        check("sat_lo",       a_rgb, 24'h008800);
        check("sat_lo_trunc", b_rgb, 24'h008700);

        // gating
        hold(24'hFF8080, 1'b0);
        check("gate_on",  a_rgb, 24'h000000);
        check("gate_off", b_rgb, 24'hFFFFFF);

        // sync alignment: vsync pulse, then a 10-pixel ramp
        step(1'b1, 1'b0, 1'b0, 24'h008080);
        step(1'b0, 1'b0, 1'b0, 24'h008080);
        check("vs_lag1", {23'h0, a_vsync}, 24'h0);
        step(1'b0, 1'b0, 1'b0, 24'h008080);
        check("vs_lag2", {23'h0, a_vsync}, 24'h1);
        step(1'b0, 1'b0, 1'b0, 24'h008080);
        check("vs_fall", {23'h0, a_vsync}, 24'h0);
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b1, 1'b1, {8'(16 + 20*k), 16'h8080});
            if (k == 1) check("href_lag2", {23'h0, a_href}, 24'h0);
            if (k == 2) begin
                check("href_lag3", {23'h0, a_href}, 24'h1);
                check("ramp_first", a_rgb, 24'h101010);
            end
        end
        step(1'b0, 1'b0, 1'b0, 24'h008080);
        step(1'b0, 1'b0, 1'b0, 24'h008080);
        check("ramp_last", a_rgb, 24'hC4C4C4);
        step(1'b0, 1'b0, 1'b0, 24'h008080);
        check("href_fall", {23'h0, a_href}, 24'h0);

        // line boundary: one idle cycle between two bursts
        for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b1, {8'(40*k), 16'h8080});
        step(1'b0, 1'b0, 1'b0, 24'h008080);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b1, {8'(255 - 30*k), 16'h7090});
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, 24'h0);

        // reset mid-line
        for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b1, {8'(50 + k), 16'h8080});
        rst = 1'b1;
        step(1'b0, 1'b1, 1'b1, 24'h5A8080);
        check("mid_rst_rgb",  a_rgb, 24'h0);
        check("mid_rst_href", {23'h0, a_href}, 24'h0);
        rst = 1'b0;
        step(1'b0, 1'b1, 1'b1, 24'h648080);
        check("post_rst_1", a_rgb, 24'h0);
        step(1'b0, 1'b1, 1'b1, 24'h658080);
        check("post_rst_2", a_rgb, 24'h0);
        step(1'b0, 1'b1, 1'b1, 24'h668080);
        check("post_rst_3", a_rgb, 24'h646464);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, 24'h0);

        // corner grid and dense random sweep, checked by the model process
        for (int a = 0; a < 7; a++)
            for (int b = 0; b < 7; b++)
                for (int c = 0; c < 7; c++)
                    step(1'b0, 1'b1, 1'b1, {corner[a], corner[b], corner[c]});
        for (int k = 0; k < 4000; k++)
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 3) != 0), 24'($urandom));
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b0, 24'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
